// File: rtl/sort_egress_dispatch_pkg.sv
// sort_egress_dispatch_pkg: shared widths, field offsets and FSM type for the sort network receive end.
// Acts as the shared define set: `PORT_NUB_TOTAL, `DATA_WIDTH and the derived `DST_W, `WIDTH_PORT,
// `WIDTH_OUT, `DST_LSB, `SRC_LSB expressions. Each is overridable from the command line.
// Port word layout, MSB->LSB: {src[DST_W], dst[DST_W], data[DATA_WIDTH]}.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef DST_W
`define DST_W ($clog2(`PORT_NUB_TOTAL))
`endif
`ifndef WIDTH_PORT
`define WIDTH_PORT (2*`DST_W + `DATA_WIDTH)
`endif
`ifndef WIDTH_OUT
`define WIDTH_OUT (`DST_W + `DATA_WIDTH)
`endif
`ifndef DST_LSB
`define DST_LSB (`DATA_WIDTH)
`endif
`ifndef SRC_LSB
`define SRC_LSB (`DST_W + `DATA_WIDTH)
`endif

package sort_egress_dispatch_pkg;
    localparam int PORT_NUB_TOTAL = `PORT_NUB_TOTAL;
    localparam int DATA_W         = `DATA_WIDTH;
    localparam int DST_W          = `DST_W;
    localparam int WIDTH_PORT     = `WIDTH_PORT;
    localparam int WIDTH_OUT      = `WIDTH_OUT;
    localparam int DST_LSB        = `DST_LSB;
    localparam int SRC_LSB        = `SRC_LSB;
    typedef enum logic {S_IDLE, S_DRAIN} state_e;
endpackage

// File: rtl/egress_fifo.sv
// egress_fifo: per-port egress queue with registered occupancy count.
// Ports: clk, rst (sync, active-high); push/push_data in, full out; pop in, pop_data/empty out.
// pop_data reads as zero while empty.
module egress_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    // full comes from the registered count, so a same-cycle pop never makes room for a push
    assign full     = cnt_q == (PW+1)'(DEPTH);
    assign empty    = cnt_q == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem_q[rd_q];
    always_comb begin
        wr_d  = wr_q + PW'(do_push);
        rd_d  = rd_q + PW'(do_pop);
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_q] <= push_data;
    end
endmodule

// File: rtl/sort_egress_dispatch.sv
// sort_egress_dispatch: delivers each word of a sorted port vector to the egress FIFO of its dst port.
// Ports: clk, rst (sync, active-high); in_valid/in_mask/in_data/in_ready vector handshake;
// out_valid/out_ready/out_data per-port egress ({src,data}); err_drop pulses when a dst >= PORT_NUB word is dropped.
// Optional macro SORT_EGRESS_STATS_EN adds stat_cnt: one 32-bit pop counter per port.
module sort_egress_dispatch
    import sort_egress_dispatch_pkg::*;
#(
    parameter int PORT_NUB   = PORT_NUB_TOTAL,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [PORT_NUB-1:0]            in_mask,
    input  logic [PORT_NUB*WIDTH_PORT-1:0] in_data,
    output logic                           in_ready,
    output logic [PORT_NUB-1:0]            out_valid,
    input  logic [PORT_NUB-1:0]            out_ready,
    output logic [PORT_NUB*WIDTH_OUT-1:0]  out_data,
    output logic                           err_drop
`ifdef SORT_EGRESS_STATS_EN
    ,
    output logic [PORT_NUB*32-1:0]         stat_cnt
`endif
);
    localparam int IDX_W = PORT_NUB > 1 ? $clog2(PORT_NUB) : 1;
    state_e state_q, state_d;
    logic [PORT_NUB*WIDTH_PORT-1:0] vec_q, vec_d;
    logic [PORT_NUB-1:0] pending_q, pending_d, drop, push, full, empty, pop, clr_all;
    logic in_ready_q, in_ready_d, err_drop_q, err_drop_d;
    logic [DST_W-1:0] src [PORT_NUB];
    logic [DST_W-1:0] dst [PORT_NUB];
    logic [DATA_W-1:0] data [PORT_NUB];
    logic [PORT_NUB-1:0] clr [PORT_NUB];

    for (genvar i = 0; i < PORT_NUB; i++) begin : g_slot
        assign src[i]  = vec_q[i*WIDTH_PORT + SRC_LSB +: DST_W];
        assign dst[i]  = vec_q[i*WIDTH_PORT + DST_LSB +: DST_W];
        assign data[i] = vec_q[i*WIDTH_PORT +: DATA_W];
        assign drop[i] = pending_q[i] && 32'(dst[i]) >= PORT_NUB;
    end

    for (genvar p = 0; p < PORT_NUB; p++) begin : g_port
        logic sel_v;
        logic [IDX_W-1:0] sel_i;
        // descending scan so the lowest pending slot aimed at this port wins
        always_comb begin
            sel_v = 1'b0;
            sel_i = '0;
            for (int i = PORT_NUB - 1; i >= 0; i--) begin
                if (pending_q[i] && 32'(dst[i]) == p) begin
                    sel_v = 1'b1;
                    sel_i = IDX_W'(i);
                end
            end
        end
        assign push[p]      = state_q == S_DRAIN && sel_v && !full[p];
        assign clr[p]       = push[p] ? PORT_NUB'(1) << sel_i : '0;
        assign out_valid[p] = !empty[p];
        assign pop[p]       = out_valid[p] && out_ready[p];
        egress_fifo #(.WIDTH(WIDTH_OUT), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[p]),
            .push_data ({src[sel_i], data[sel_i]}),
            .full      (full[p]),
            .pop       (pop[p]),
            .pop_data  (out_data[p*WIDTH_OUT +: WIDTH_OUT]),
            .empty     (empty[p])
        );
`ifdef SORT_EGRESS_STATS_EN
        logic [31:0] stat_q, stat_d;
        assign stat_d = stat_q + 32'(pop[p]);
        always_ff @(posedge clk) stat_q <= rst ? '0 : stat_d;
        assign stat_cnt[p*32 +: 32] = stat_q;
`endif
    end

    always_comb begin
        clr_all = '0;
        for (int i = 0; i < PORT_NUB; i++) clr_all = clr_all | clr[i];
    end

    // in_ready is only high in IDLE, so an accept never overlaps a drain
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pending_d  = pending_q;
        in_ready_d = in_ready_q;
        err_drop_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (in_valid) begin
                vec_d      = in_data;
                pending_d  = in_mask;
                state_d    = in_mask != '0 ? S_DRAIN : S_IDLE;
                in_ready_d = in_mask == '0;
            end
        end else begin
            pending_d  = pending_q & ~(clr_all | drop);
            err_drop_d = |drop;
            if (pending_d == '0) begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            pending_q  <= '0;
            in_ready_q <= 1'b1;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            pending_q  <= pending_d;
            in_ready_q <= in_ready_d;
            err_drop_q <= err_drop_d;
        end
    end

    assign in_ready = in_ready_q;
    assign err_drop = err_drop_q;
endmodule
